i2c_slave_regfile: RTL and testbench

I2C target (slave) responder; the counterpart to the I2C master interface used by the sensor designs. It sits on the same SCL/SDA open-drain pins and exposes a small byte-wide register file. An external I2C master can write and read that register file using the standard pointer-then-data protocol. The local logic reads and writes the same registers through a simple host port, so the block can serve as a bench peer for the master and as a board-level config target.

---
 rtl/i2c_slave_regfile.sv | 182 ++++++++++++++++++
 tb/tb_i2c_slave_regfile.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regfile.sv
// i2c_slave_regfile: I2C target exposing a byte-wide register file to an external master and a local host port.
// SCL/SDA are synchronized and edge-detected; SDA is only ever pulled low, never driven high.
module i2c_slave_regfile #(
   parameter logic [6:0] SLAVE_ADDR = 7'h50,
   parameter int         NUM_REGS   = 16,
   parameter int         PTR_W      = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             scl_pad_i,
   output logic             scl_pad_o,
   output logic             scl_padoen_o,
   input  logic             sda_pad_i,
   output logic             sda_pad_o,
   output logic             sda_padoen_o,
   input  logic [PTR_W-1:0] host_addr,
   input  logic [7:0]       host_wdata,
   input  logic             host_we,
   output logic [7:0]       host_rdata,
   output logic             wr_strobe,
   output logic [PTR_W-1:0] wr_addr,
   output logic [7:0]       wr_data,
   output logic             busy
);
   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK_WAIT, IGNORE
   } state_t;

   state_t           state_q;
   logic [2:0]       scl_q, sda_q;
   logic [3:0]       cnt_q;
   logic [7:0]       sh_q, tx_q, host_rdata_q, wr_data_q, rd_byte;
   logic [PTR_W-1:0] ptr_q, wr_addr_q;
   logic             rw_q, padoen_q, busy_q, wr_strobe_q;
   logic             scl_rise, scl_fall, start, stop, sda_s, commit;
   logic [7:0]       regs_q [NUM_REGS];
   logic [7:0]       regs_d [NUM_REGS];

   assign scl_pad_o    = 1'b0;
   assign scl_padoen_o = 1'b1;
   assign sda_pad_o    = 1'b0;
   assign sda_padoen_o = padoen_q;
   assign host_rdata   = host_rdata_q;
   assign wr_strobe    = wr_strobe_q;
   assign wr_addr      = wr_addr_q;
   assign wr_data      = wr_data_q;
   assign busy         = busy_q;

   // bit 1 is the synchronized level, bit 2 its one-cycle history
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         scl_q <= '1;
         sda_q <= '1;
      end else begin
         scl_q <= {scl_q[1:0], scl_pad_i};
         sda_q <= {sda_q[1:0], sda_pad_i};
      end
   end

   assign sda_s    = sda_q[1];
   assign scl_rise = scl_q[1] & ~scl_q[2];
   assign scl_fall = ~scl_q[1] & scl_q[2];
   assign start    = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
   assign stop     = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];
   assign rd_byte  = regs_q[ptr_q];
   assign commit   = (state_q == WDATA) && scl_fall && !start && !stop && (cnt_q == 4'd8);

   // an I2C commit is applied after the host write so it wins on a same-index collision
   always_comb begin
      regs_d = regs_q;
      if (host_we) regs_d[host_addr] = host_wdata;
      if (commit) regs_d[ptr_q] = sh_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         regs_q       <= '{default: '0};
         host_rdata_q <= '0;
      end else begin
         regs_q       <= regs_d;
         host_rdata_q <= regs_d[host_addr];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         sh_q        <= '0;
         tx_q        <= '0;
         ptr_q       <= '0;
         rw_q        <= 1'b0;
         padoen_q    <= 1'b1;
         busy_q      <= 1'b0;
         wr_strobe_q <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
      end else begin
         wr_strobe_q <= 1'b0;
         if (stop) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            padoen_q <= 1'b1;
         end else if (start) begin
            state_q  <= ADDR;
            cnt_q    <= '0;
            padoen_q <= 1'b1;
         end else if (scl_rise) begin
            if (state_q inside {ADDR, PTR, WDATA}) begin
               sh_q  <= {sh_q[6:0], sda_s};
               cnt_q <= cnt_q + 4'd1;
            end else if (state_q == RACK_WAIT) begin
               if (sda_s) state_q <= IGNORE;
               else cnt_q <= 4'd1;
            end
         end else if (scl_fall) begin
            case (state_q)
               ADDR: if (cnt_q == 4'd8) begin
                  cnt_q <= '0;
                  if (sh_q[7:1] == SLAVE_ADDR) begin
                     rw_q     <= sh_q[0];
                     padoen_q <= 1'b0;
                     busy_q   <= 1'b1;
                     state_q  <= ADDR_ACK;
                  end else begin
                     state_q <= IGNORE;
                  end
               end
               ADDR_ACK: if (rw_q) begin
                  tx_q     <= {rd_byte[6:0], 1'b0};
                  padoen_q <= rd_byte[7];
                  cnt_q    <= 4'd1;
                  state_q  <= RDATA;
               end else begin
                  padoen_q <= 1'b1;
                  state_q  <= PTR;
               end
               PTR: if (cnt_q == 4'd8) begin
                  ptr_q    <= sh_q[PTR_W-1:0];
                  padoen_q <= 1'b0;
                  cnt_q    <= '0;
                  state_q  <= PTR_ACK;
               end
               PTR_ACK: begin
                  padoen_q <= 1'b1;
                  state_q  <= WDATA;
               end
               WDATA: if (cnt_q == 4'd8) begin
                  wr_strobe_q <= 1'b1;
                  wr_addr_q   <= ptr_q;
                  wr_data_q   <= sh_q;
                  ptr_q       <= ptr_q + PTR_W'(1);
                  padoen_q    <= 1'b0;
                  cnt_q       <= '0;
                  state_q     <= WDATA_ACK;
               end
               WDATA_ACK: begin
                  padoen_q <= 1'b1;
                  state_q  <= WDATA;
               end
               RDATA: if (cnt_q == 4'd8) begin
                  padoen_q <= 1'b1;
                  ptr_q    <= ptr_q + PTR_W'(1);
                  cnt_q    <= '0;
                  state_q  <= RACK_WAIT;
               end else begin
                  padoen_q <= tx_q[7];
                  tx_q     <= {tx_q[6:0], 1'b0};
                  cnt_q    <= cnt_q + 4'd1;
               end
               // cnt_q==1 marks that the master ACKed on the preceding rising edge
               RACK_WAIT: if (cnt_q == 4'd1) begin
                  tx_q     <= {rd_byte[6:0], 1'b0};
                  padoen_q <= rd_byte[7];
                  state_q  <= RDATA;
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_i2c_slave_regfile.sv
// tb_i2c_slave_regfile: bit-banged I2C master plus host-port driver, checked against an array/pointer model of the register file.
module tb_i2c_slave_regfile;
   localparam int Q = 5;
   localparam logic [7:0] AW = 8'hA0, AR = 8'hA1;

   logic clk = 1'b0, reset = 1'b0;
   logic m_scl = 1'b1, m_sda = 1'b1;
   logic sda_line;
   logic scl_pad_o, scl_padoen_o, sda_pad_o, sda_padoen_o;
   logic [3:0] host_addr = '0;
   logic [7:0] host_wdata = '0;
   logic host_we = 1'b0;
   logic [7:0] host_rdata, wr_data;
   logic [3:0] wr_addr;
   logic wr_strobe, busy;

   int n_cmp = 0, n_err = 0;
   logic [7:0] mregs [16];
   int mptr = 0;
   logic [11:0] exp_q[$], got_q[$];
   logic [7:0] data_q[$];
   logic coll = 1'b0, mon_en = 1'b0, drove = 1'b0;

   always #5 clk = ~clk;

   assign sda_line = m_sda & (sda_padoen_o | sda_pad_o);

   i2c_slave_regfile dut (
      .clk(clk), .reset(reset),
      .scl_pad_i(m_scl & (scl_padoen_o | scl_pad_o)), .scl_pad_o(scl_pad_o), .scl_padoen_o(scl_padoen_o),
      .sda_pad_i(sda_line), .sda_pad_o(sda_pad_o), .sda_padoen_o(sda_padoen_o),
      .host_addr(host_addr), .host_wdata(host_wdata), .host_we(host_we), .host_rdata(host_rdata),
      .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
   );

   always @(negedge clk) begin
      if (wr_strobe) got_q.push_back({wr_addr, wr_data});
      if (mon_en && !sda_padoen_o) drove = 1'b1;
   end

   initial begin
      repeat (80000) @(posedge clk);
      $display("FAIL watchdog: run did not complete");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic xfer_bit(input logic b, output logic s);
      repeat (Q) @(negedge clk); m_sda = b;
      repeat (Q) @(negedge clk); m_scl = 1'b1;
      repeat (Q) @(negedge clk); s = sda_line;
      repeat (Q) @(negedge clk); m_scl = 1'b0;
   endtask

   task automatic i2c_start();
      repeat (Q) @(negedge clk); m_sda = 1'b1;
      repeat (Q) @(negedge clk); m_scl = 1'b1;
      repeat (Q) @(negedge clk); m_sda = 1'b0;
      repeat (Q) @(negedge clk); m_scl = 1'b0;
   endtask

   task automatic i2c_stop();
      repeat (Q) @(negedge clk); m_sda = 1'b0;
      repeat (Q) @(negedge clk); m_scl = 1'b1;
      repeat (Q) @(negedge clk); m_sda = 1'b1;
      repeat (2 * Q) @(negedge clk);
   endtask

   // optional collision: host write to index 4 lands on the same clk edge as the I2C commit
   task automatic write_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) xfer_bit(b[i], s);
      if (coll) begin
         @(negedge clk); @(negedge clk);
         host_addr = 4'd4; host_wdata = 8'hFF; host_we = 1'b1;
         @(negedge clk);
         host_we = 1'b0; coll = 1'b0;
      end
      xfer_bit(1'b1, ack);
   endtask

   task automatic read_byte(output logic [7:0] b, input logic nack);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         xfer_bit(1'b1, s);
         b[i] = s;
      end
      xfer_bit(nack, s);
   endtask

   task automatic host_write(input logic [3:0] a, input logic [7:0] d);
      @(negedge clk); host_addr = a; host_wdata = d; host_we = 1'b1;
      @(negedge clk); host_we = 1'b0;
      mregs[a] = d;
   endtask

   task automatic host_check(input string tag, input logic [3:0] a);
      @(negedge clk); host_addr = a;
      @(negedge clk); chk(tag, host_rdata, mregs[a]);
   endtask

   task automatic check_strobes();
      chk("strobe_count", got_q.size(), exp_q.size());
      while (exp_q.size() > 0 && got_q.size() > 0) chk("strobe", got_q.pop_front(), exp_q.pop_front());
      got_q.delete(); exp_q.delete();
   endtask

   task automatic wr_txn(input logic [7:0] p, input int n);
      logic a;
      logic [7:0] d;
      i2c_start();
      write_byte(AW, a); chk("wr_addr_ack", a, 0);
      write_byte(p, a); chk("wr_ptr_ack", a, 0);
      mptr = p % 16;
      for (int i = 0; i < n; i++) begin
         d = data_q.pop_front();
         write_byte(d, a); chk("wr_data_ack", a, 0);
         mregs[mptr] = d;
         exp_q.push_back({4'(mptr), d});
         mptr = (mptr + 1) % 16;
      end
      chk("busy_mid", busy, 1);
      i2c_stop();
      chk("busy_end", busy, 0);
      check_strobes();
   endtask

   task automatic rd_txn(input logic set_ptr, input logic [7:0] p, input int n);
      logic a;
      logic [7:0] b;
      i2c_start();
      if (set_ptr) begin
         write_byte(AW, a); chk("rd_waddr_ack", a, 0);
         write_byte(p, a); chk("rd_ptr_ack", a, 0);
         mptr = p % 16;
         i2c_start();
      end
      write_byte(AR, a); chk("rd_addr_ack", a, 0);
      for (int i = 0; i < n; i++) begin
         read_byte(b, i == n - 1);
         chk("rd_data", b, mregs[mptr]);
         mptr = (mptr + 1) % 16;
      end
      chk("rd_release", sda_padoen_o, 1);
      i2c_stop();
      chk("rd_busy_end", busy, 0);
      check_strobes();
   endtask

   initial begin
      logic a, s;
      logic [7:0] p;
      for (int i = 0; i < 16; i++) mregs[i] = '0;
      repeat (3) @(negedge clk);
      chk("rst_padoen", sda_padoen_o, 1);
      chk("rst_busy", busy, 0);
      chk("rst_strobe", wr_strobe, 0);
      chk("rst_rdata", host_rdata, 0);
      reset = 1'b1;
      repeat (5) @(negedge clk);

      data_q = '{8'hA5, 8'h5A};
      wr_txn(8'h03, 2);
      host_check("reg3", 4'd3);
      host_check("reg4", 4'd4);
      chk("reg4_const", host_rdata, 8'h5A);
      rd_txn(1'b1, 8'h03, 2);

      mon_en = 1'b1; drove = 1'b0;
      i2c_start();
      write_byte(8'hA2, a); chk("mis_ack", a, 1);
      write_byte(8'h00, a);
      chk("mis_busy", busy, 0);
      i2c_stop();
      mon_en = 1'b0;
      chk("mis_drive", drove, 0);
      check_strobes();

      data_q = '{8'h11, 8'h22};
      wr_txn(8'h0F, 2);
      host_check("wrap_reg15", 4'd15);
      host_check("wrap_reg0", 4'd0);
      rd_txn(1'b0, 8'h00, 1);

      p = 8'($urandom);
      i2c_start();
      write_byte(AW, a); chk("abort_addr_ack", a, 0);
      write_byte(p, a); chk("abort_ptr_ack", a, 0);
      mptr = p % 16;
      for (int i = 0; i < 4; i++) xfer_bit(1'($urandom), s);
      i2c_stop();
      chk("abort_busy", busy, 0);
      check_strobes();
      rd_txn(1'b0, 8'h00, 1);

      i2c_start();
      write_byte(AW, a); chk("coll_addr_ack", a, 0);
      write_byte(8'h04, a); chk("coll_ptr_ack", a, 0);
      coll = 1'b1;
      write_byte(8'h5A, a); chk("coll_data_ack", a, 0);
      i2c_stop();
      mregs[4] = 8'h5A; exp_q.push_back({4'd4, 8'h5A}); mptr = 5;
      check_strobes();
      host_check("coll_reg4", 4'd4);

      for (int it = 0; it < 15; it++) begin
         case ($urandom_range(0, 2))
            0: host_write(4'($urandom), 8'($urandom));
            1: begin
               int n = $urandom_range(1, 4);
               for (int i = 0; i < n; i++) data_q.push_back(8'($urandom));
               wr_txn(8'($urandom), n);
            end
            default: rd_txn(1'($urandom), 8'($urandom), $urandom_range(1, 3));
         endcase
      end

      host_write(4'(mptr), 8'h3C);
      i2c_start();
      write_byte(AR, a); chk("rst_rd_ack", a, 0);
      repeat (Q) @(negedge clk);
      chk("rst_rd_bit7", sda_padoen_o, 0);
      #2 reset = 1'b0;
      #1 chk("rst_async_release", sda_padoen_o, 1);
      chk("rst_async_busy", busy, 0);
      chk("rst_async_rdata", host_rdata, 0);
      for (int i = 0; i < 16; i++) mregs[i] = '0;
      mptr = 0;
      got_q.delete();
      repeat (3) @(negedge clk);
      reset = 1'b1;
      i2c_stop();
      for (int i = 0; i < 16; i++) host_write(4'(i), 8'($urandom));
      rd_txn(1'b0, 8'h00, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
